alu_op_sequencer: RTL and testbench

- Control FSM that drives the strobes of the two-function 8-bit ALU: operand register A load, operand register B load, add/subtract select, result register load, and register clear.
- Converts a single user "Enter" key plus an Op switch into correctly spaced, glitch-free, single-clock-domain strobes.
- Waits a programmable settle time for the ripple-carry adder before loading R.
- Latches carry and overflow flags at the moment R is loaded.

---
 rtl/alu_op_sequencer.sv | 159 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Purpose : sequence the strobes of the 8-bit add/sub ALU from a single Enter key plus an Op switch.
// Latency : a sampled Enter rise shows on the strobe one edge later; LoadR follows LoadB after SETTLE_CYC idle cycles.
// Backpres: none; Enter rises outside WAIT_A/WAIT_B/DONE are dropped, and Clear aborts at once.
//
// Ports:
//   CLK, Reset (sync, active-low), Enter (key level), Op (0 add / 1 sub), Clear (sync abort)
//   Cout_in, OVR_in       - adder flags from the datapath
//   LoadA/LoadB/LoadR     - operand/result register strobes, PULSE_W cycles each
//   ADDSUB, RegClr        - adder mode and register clear
//   Busy, Done, CoutFlag, OvrFlag, State - status and debug
module alu_op_sequencer #(
    parameter int PULSE_W    = 2,
    parameter int SETTLE_CYC = 4
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Enter,
    input  logic       Op,
    input  logic       Clear,
    input  logic       Cout_in,
    input  logic       OVR_in,
    output logic       LoadA,
    output logic       LoadB,
    output logic       LoadR,
    output logic       ADDSUB,
    output logic       RegClr,
    output logic       Busy,
    output logic       Done,
    output logic       CoutFlag,
    output logic       OvrFlag,
    output logic [2:0] State
);

    localparam int CMAX = (PULSE_W > SETTLE_CYC) ? PULSE_W : SETTLE_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] PW_LAST  = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYC - 1);

    // Code 7 is deliberately left unused; it falls into the default arm.
    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        PULSE_A = 3'd1,
        WAIT_B  = 3'd2,
        PULSE_B = 3'd3,
        SETTLE  = 3'd4,
        PULSE_R = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            enter_q;
    logic            enter_rise;
    logic            timed;
    logic            addsub_d, cflag_d, oflag_d, regclr_d;

    assign enter_rise = Enter & ~enter_q;
    assign State      = state_q;

    always_comb begin
        state_d  = state_q;
        addsub_d = ADDSUB;
        cflag_d  = CoutFlag;
        oflag_d  = OvrFlag;
        regclr_d = 1'b0;
        timed    = 1'b0;
        cnt_d    = '0;

        case (state_q)
            WAIT_A: begin
                if (enter_rise) state_d = PULSE_A;
            end
            PULSE_A: begin
                timed = 1'b1;
                if (cnt_q == PW_LAST) state_d = WAIT_B;
            end
            WAIT_B: begin
                if (enter_rise) begin
                    addsub_d = Op;
                    state_d  = PULSE_B;
                end
            end
            PULSE_B: begin
                timed = 1'b1;
                if (cnt_q == PW_LAST) state_d = SETTLE;
            end
            SETTLE: begin
                timed = 1'b1;
                if (cnt_q == SET_LAST) state_d = PULSE_R;
            end
            PULSE_R: begin
                timed = 1'b1;
                // Operands have been stable for the whole settle window here.
                if (cnt_q == '0) begin
                    cflag_d = Cout_in;
                    oflag_d = OVR_in;
                end
                if (cnt_q == PW_LAST) state_d = DONE;
            end
            DONE: begin
                if (enter_rise) state_d = PULSE_A;
            end
            default: begin
                state_d  = WAIT_A;
                regclr_d = 1'b1;
            end
        endcase

        // The previous result's flags live until the next LoadA begins.
        if (state_d == PULSE_A && state_q != PULSE_A) begin
            cflag_d = 1'b0;
            oflag_d = 1'b0;
        end

        // Clear wins over everything, including a same-cycle Enter rise.
        if (Clear) begin
            state_d  = WAIT_A;
            regclr_d = 1'b1;
            addsub_d = 1'b0;
            cflag_d  = 1'b0;
            oflag_d  = 1'b0;
        end

        // Terminal-count timer restarted on every state entry.
        if (timed && state_d == state_q) cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q  <= WAIT_A;
            cnt_q    <= '0;
            enter_q  <= 1'b1;   // a key held through reset must not fire
            LoadA    <= 1'b0;
            LoadB    <= 1'b0;
            LoadR    <= 1'b0;
            ADDSUB   <= 1'b0;
            RegClr   <= 1'b1;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            CoutFlag <= 1'b0;
            OvrFlag  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            enter_q  <= Enter;
            // Outputs decode the next state so they change with State itself.
            LoadA    <= (state_d == PULSE_A);
            LoadB    <= (state_d == PULSE_B);
            LoadR    <= (state_d == PULSE_R);
            Busy     <= (state_d inside {PULSE_A, PULSE_B, SETTLE, PULSE_R});
            Done     <= (state_d == DONE);
            ADDSUB   <= addsub_d;
            RegClr   <= regclr_d;
            CoutFlag <= cflag_d;
            OvrFlag  <= oflag_d;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    localparam int PULSE_W    = 2;
    localparam int SETTLE_CYC = 4;

    logic       clk = 1'b0;
    logic       rst_n, enter, op, clear, cout_in, ovr_in;
    logic       load_a, load_b, load_r, addsub, reg_clr, busy, done, cout_flag, ovr_flag;
    logic [2:0] state;

    alu_op_sequencer #(.PULSE_W(PULSE_W), .SETTLE_CYC(SETTLE_CYC)) dut (
        .CLK(clk), .Reset(rst_n), .Enter(enter), .Op(op), .Clear(clear),
        .Cout_in(cout_in), .OVR_in(ovr_in),
        .LoadA(load_a), .LoadB(load_b), .LoadR(load_r), .ADDSUB(addsub),
        .RegClr(reg_clr), .Busy(busy), .Done(done), .CoutFlag(cout_flag),
        .OvrFlag(ovr_flag), .State(state)
    );

    always #5 clk = ~clk;

    // Bench datapath: operand/result registers and ripple adder.
    logic [7:0] din, ra_q, rb_q, rr_q, bop;
    logic [8:0] sum;
    always_ff @(posedge clk) begin
        if (reg_clr) begin
            ra_q <= '0; rb_q <= '0; rr_q <= '0;
        end else begin
            if (load_a) ra_q <= din;
            if (load_b) rb_q <= din;
            if (load_r) rr_q <= sum[7:0];
        end
    end
    always_comb begin
        bop     = addsub ? ~rb_q : rb_q;
        sum     = {1'b0, ra_q} + {1'b0, bop} + {8'd0, addsub};
        cout_in = sum[8];
        ovr_in  = (ra_q[7] == bop[7]) && (sum[7] != ra_q[7]);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard entry: {addsub, ovr, cout, r}
    logic [10:0] sb[$];
    logic        exp_op;

    function automatic logic [10:0] expect_res(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic [7:0] r;
        logic       c, v;
        if (s) begin
            r = a - b;
            c = (a >= b);
            v = (a[7] != b[7]) && (r[7] != a[7]);
        end else begin
            {c, r} = {1'b0, a} + {1'b0, b};
            v = (a[7] == b[7]) && (r[7] != a[7]);
        end
        return {s, v, c, r};
    endfunction

    // Monitor: strobe widths, spacing, exclusion, settle gap, state log, scoreboard pop.
    logic [2:0] sp;
    logic       done_p, as_p;
    int         run[3];
    int         rises[3];
    int         low_cnt;
    logic [2:0] st_log[$];
    logic [2:0] st_prev;

    always @(negedge clk) begin
        logic [2:0] s;
        logic [10:0] e;
        s = {load_r, load_b, load_a};
        if (rst_n) begin
            chk("excl", ($countones(s) <= 1), 1);
            for (int i = 0; i < 3; i++) begin
                if (s[i] && !sp[i]) begin
                    rises[i]++;
                    chk("gap", (sp != 3'b000), 0);
                    if (i == 1) chk("addsub_b", addsub, exp_op);
                    if (i == 2) chk("settle", low_cnt, SETTLE_CYC);
                end
                if (s[i]) run[i]++;
                else if (sp[i]) begin
                    chk("width", run[i], PULSE_W);
                    run[i] = 0;
                end
            end
            if (sp[1] && !s[1]) low_cnt = 1;
            else if (s == 3'b000) low_cnt++;
            if (load_r || state == 3'd4) chk("as_stable", addsub, as_p);
            if (done && !done_p) begin
                if (sb.size() == 0) chk("sb_empty", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("R", rr_q, e[7:0]);
                    chk("cout", cout_flag, e[8]);
                    chk("ovr", ovr_flag, e[9]);
                    chk("addsub", addsub, e[10]);
                    chk("busy_done", busy, 0);
                end
            end
            if (state != st_prev) st_log.push_back(state);
        end else begin
            for (int i = 0; i < 3; i++) run[i] = 0;
        end
        sp      = s;
        done_p  = done;
        as_p    = addsub;
        st_prev = state;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press();
        enter = 1'b1; cyc(1);
        enter = 1'b0; cyc(1);
    endtask

    task automatic wait_state(input logic [2:0] s);
        for (int i = 0; i < 100; i++) begin
            if (state == s) break;
            cyc(1);
        end
        chk("state_wait", state, s);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            if (done) break;
            cyc(1);
        end
        chk("done_wait", done, 1);
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s);
        din = a; press();
        wait_state(3'd2);
        din = b; op = s; exp_op = s;
        sb.push_back(expect_res(a, b, s));
        press();
        wait_done();
    endtask

    initial begin
        int r0[3];
        rst_n = 1'b0; enter = 1'b1; op = 1'b0; clear = 1'b0; din = '0; exp_op = 1'b0;
        low_cnt = 0;
        for (int i = 0; i < 3; i++) rises[i] = 0;

        // 1: reset with Enter held high
        cyc(3);
        chk("rst_regclr", reg_clr, 1);
        chk("rst_state", state, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        chk("rel_regclr", reg_clr, 1);
        cyc(1);
        chk("rel_regclr_off", reg_clr, 0);
        cyc(3);
        chk("held_no_loada", load_a, 0);
        chk("held_state", state, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", {cout_flag, ovr_flag}, 0);
        enter = 1'b0; cyc(1);

        // 2: add 5 + 3
        do_op(8'h05, 8'h03, 1'b0);
        chk("add_R", rr_q, 8'h08);

        // 3: subtract with overflow 0x80 - 1
        do_op(8'h80, 8'h01, 1'b1);
        chk("sub_flags", {cout_flag, ovr_flag}, 2'b11);
        chk("sub_R", rr_q, 8'h7F);

        // Clear from DONE, with a same-cycle Enter rise that must be discarded
        clear = 1'b1; enter = 1'b1; cyc(1);
        chk("clr_state", state, 0);
        chk("clr_regclr", reg_clr, 1);
        chk("clr_done", done, 0);
        chk("clr_flags", {cout_flag, ovr_flag}, 0);
        chk("clr_addsub", addsub, 0);
        cyc(1);
        chk("clr_hold_regclr", reg_clr, 1);
        clear = 1'b0; cyc(1);
        chk("clr_regclr_off", reg_clr, 0);
        cyc(2);
        chk("clr_enter_dropped", state, 0);
        enter = 1'b0; cyc(1);

        // 4: Enter rises injected in busy states are ignored
        r0 = rises;
        st_log.delete(); st_log.push_back(state);
        din = 8'h3C;
        enter = 1'b1; cyc(1);
        enter = 1'b0; cyc(1);
        enter = 1'b1; cyc(3);
        enter = 1'b0; cyc(1);
        chk("inj_waitb", state, 2);
        din = 8'h0F; op = 1'b1; exp_op = 1'b1;
        sb.push_back(expect_res(8'h3C, 8'h0F, 1'b1));
        for (int k = 0; k < 9; k++) begin
            enter = (k % 2 == 0); cyc(1);
        end
        enter = 1'b0;
        wait_done();
        cyc(3);
        chk("inj_stay_done", state, 6);
        for (int i = 0; i < 3; i++) chk("inj_one_strobe", rises[i] - r0[i], 1);
        chk("seq_len", st_log.size(), 7);
        for (int i = 0; i < 7 && i < st_log.size(); i++) chk("seq", st_log[i], i);

        // 5: Clear during SETTLE aborts before LoadR
        clear = 1'b1; cyc(1); clear = 1'b0; cyc(1);
        r0 = rises;
        din = 8'h11; press();
        wait_state(3'd2);
        din = 8'h22; op = 1'b0; exp_op = 1'b0;
        press();
        wait_state(3'd4);
        clear = 1'b1; cyc(1); clear = 1'b0;
        chk("abort_state", state, 0);
        chk("abort_regclr", reg_clr, 1);
        chk("abort_done", done, 0);
        chk("abort_flags", {cout_flag, ovr_flag}, 0);
        cyc(1);
        chk("abort_regclr_off", reg_clr, 0);
        cyc(10);
        chk("abort_no_loadr", rises[2] - r0[2], 0);
        chk("abort_idle", state, 0);

        // 6: flags and Done hold until LoadA, then 0x7F + 1
        do_op(8'h80, 8'h01, 1'b1);
        din = 8'h7F; enter = 1'b1;
        chk("hold_done", done, 1);
        chk("hold_flags", {cout_flag, ovr_flag}, 2'b11);
        cyc(1);
        chk("new_loada", load_a, 1);
        chk("new_done_low", done, 0);
        enter = 1'b0; cyc(1);
        wait_state(3'd2);
        din = 8'h01; op = 1'b0; exp_op = 1'b0;
        sb.push_back(expect_res(8'h7F, 8'h01, 1'b0));
        press();
        wait_done();
        chk("ovf_flags", {cout_flag, ovr_flag}, 2'b01);
        chk("ovf_R", rr_q, 8'h80);

        cyc(2);
        chk("sb_left", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
